obi_xbar_n_to_one_rr: RTL and testbench



---
 rtl/obi_pkg.sv | 22 ++
 rtl/obi_xbar_pkg.sv | 30 +++
 rtl/obi_xbar_id_fifo.sv | 62 ++++++
 rtl/obi_xbar_n_to_one_rr.sv | 163 ++++++++++++++++
 tb/tb_obi_xbar_n_to_one_rr.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/obi_pkg.sv
// OBI bus payload types shared by masters, slaves and interconnect.
package obi_pkg;

    localparam int unsigned OBI_ADDR_W = 32;
    localparam int unsigned OBI_DATA_W = 32;
    localparam int unsigned OBI_BE_W   = OBI_DATA_W / 8;

    typedef struct packed {
        logic                  req;
        logic                  we;
        logic [OBI_BE_W-1:0]   be;
        logic [OBI_ADDR_W-1:0] addr;
        logic [OBI_DATA_W-1:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic                  gnt;
        logic                  rvalid;
        logic [OBI_DATA_W-1:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/obi_xbar_pkg.sv
// Arbitration constants, lock states and round-robin pick helper for obi_xbar_n_to_one_rr.
package obi_xbar_pkg;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    // First eligible index at or after ptr, wrapping modulo n (n <= 32, ptr < n).
    function automatic int unsigned rr_pick(input logic [31:0] elig,
                                            input int unsigned n,
                                            input int unsigned ptr);
        int unsigned idx;
        logic        found;
        rr_pick = 0;
        found   = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            idx = ptr + i;
            if (idx >= n) idx = idx - n;
            if (!found && (i < n) && elig[idx[4:0]]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/obi_xbar_id_fifo.sv
// Synchronous FIFO holding the master index of every in-flight OBI transaction.
module obi_xbar_id_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [W-1:0]                 i_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [W-1:0]                 o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by r_count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/obi_xbar_n_to_one_rr.sv
// N-to-1 OBI arbiter (fixed priority or round-robin) with in-order response routing.
// Define OBI_XBAR_PERF_CNT_EN to add saturating per-master grant counters on gnt_cnt_o.
module obi_xbar_n_to_one_rr
    import obi_pkg::*;
    import obi_xbar_pkg::*;
#(
    parameter int unsigned NMASTER         = 3,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned ARB_MODE        = ARB_FIXED
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  obi_req_t  master_req_i  [NMASTER],
    output obi_resp_t master_resp_o [NMASTER],
    output obi_req_t  slave_req_o,
    input  obi_resp_t slave_resp_i,
    output logic      busy_o
`ifdef OBI_XBAR_PERF_CNT_EN
    ,
    output logic [31:0] gnt_cnt_o [NMASTER]
`endif
);

    localparam int unsigned IDX_W = $clog2(NMASTER);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    lock_state_e      r_state;
    lock_state_e      w_state_nxt;
    logic [IDX_W-1:0] r_lock_idx;
    logic [IDX_W-1:0] w_lock_idx_nxt;
    logic [IDX_W-1:0] r_rr_ptr;

    logic [NMASTER-1:0] w_elig;
    logic               w_any;
    logic [IDX_W-1:0]   w_fix_idx;
    logic [IDX_W-1:0]   w_rr_idx;
    logic [IDX_W-1:0]   w_pick;
    logic [IDX_W-1:0]   w_sel;
    logic               w_slave_req;
    logic               w_hs;
    logic               w_rvalid_ok;
    logic               w_full;
    logic               w_empty;
    logic [IDX_W-1:0]   w_head;
    logic [CNT_W-1:0]   w_count;

    always_comb begin
        for (int i = 0; i < int'(NMASTER); i++) begin
            w_elig[i] = master_req_i[i].req;
        end
    end

    assign w_any = |w_elig;

    // Lowest eligible index wins in fixed mode.
    always_comb begin
        w_fix_idx = '0;
        for (int i = int'(NMASTER) - 1; i >= 0; i--) begin
            if (w_elig[i]) w_fix_idx = IDX_W'(i);
        end
    end

    assign w_rr_idx = IDX_W'(rr_pick(32'(w_elig), NMASTER, 32'(r_rr_ptr)));
    assign w_pick   = (ARB_MODE == ARB_RR) ? w_rr_idx : w_fix_idx;
    assign w_sel    = (r_state == ST_LOCKED) ? r_lock_idx : w_pick;

    // A full FIFO blocks the request even if a pop lands in the same cycle.
    assign w_slave_req = !rst_i && w_any && !w_full;
    assign w_hs        = w_slave_req && slave_resp_i.gnt;
    assign w_rvalid_ok = !rst_i && slave_resp_i.rvalid && !w_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_OPEN;
            r_lock_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_idx <= w_lock_idx_nxt;
        end
    end

    // Hold an ungranted selection until the slave grants it.
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_idx_nxt = r_lock_idx;
        case (r_state)
            ST_OPEN: begin
                if (w_slave_req && !slave_resp_i.gnt) begin
                    w_state_nxt    = ST_LOCKED;
                    w_lock_idx_nxt = w_pick;
                end
            end
            ST_LOCKED: begin
                if (w_hs) w_state_nxt = ST_OPEN;
            end
            default: w_state_nxt = ST_OPEN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr <= '0;
        end else if (w_hs && (ARB_MODE == ARB_RR)) begin
            r_rr_ptr <= (w_sel == IDX_W'(NMASTER - 1)) ? '0 : w_sel + IDX_W'(1);
        end
    end

    always_comb begin
        slave_req_o = '0;
        if (w_any && !rst_i) begin
            slave_req_o = master_req_i[w_sel];
        end
        slave_req_o.req = w_slave_req;
    end

    // rdata is broadcast; only the selected/head master sees gnt/rvalid.
    always_comb begin
        for (int i = 0; i < int'(NMASTER); i++) begin
            master_resp_o[i]        = '0;
            master_resp_o[i].rdata  = slave_resp_i.rdata;
            master_resp_o[i].gnt    = w_hs && (w_sel == IDX_W'(i));
            master_resp_o[i].rvalid = w_rvalid_ok && (w_head == IDX_W'(i));
        end
    end

    assign busy_o = !rst_i && (w_count != '0);

    obi_xbar_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (IDX_W)
    ) u_id_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_hs),
        .i_pop   (w_rvalid_ok),
        .i_data  (w_sel),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head),
        .o_count (w_count)
    );

`ifdef OBI_XBAR_PERF_CNT_EN
    logic [31:0] r_gnt_cnt [NMASTER];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(NMASTER); i++) begin
            if (rst_i) begin
                r_gnt_cnt[i] <= '0;
            end else if (master_resp_o[i].gnt && (r_gnt_cnt[i] != 32'hFFFF_FFFF)) begin
                r_gnt_cnt[i] <= r_gnt_cnt[i] + 32'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NMASTER); i++) begin
            gnt_cnt_o[i] = r_gnt_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_obi_xbar_n_to_one_rr.sv
// Directed bench: fixed-priority and round-robin instances of obi_xbar_n_to_one_rr.
module tb_obi_xbar_n_to_one_rr;
    import obi_pkg::*;

    logic clk;
    logic rst;

    obi_req_t  fx_req  [3];
    obi_resp_t fx_resp [3];
    obi_req_t  fx_sreq;
    obi_resp_t fx_sresp;
    logic      fx_busy;

    obi_req_t  rr_req  [3];
    obi_resp_t rr_resp [3];
    obi_req_t  rr_sreq;
    obi_resp_t rr_sresp;
    logic      rr_busy;

`ifdef OBI_XBAR_PERF_CNT_EN
    logic [31:0] fx_cnt [3];
    logic [31:0] rr_cnt [3];
`endif

    logic [2:0] fx_gnt, fx_rv, rr_gnt, rr_rv;
    assign fx_gnt = {fx_resp[2].gnt, fx_resp[1].gnt, fx_resp[0].gnt};
    assign fx_rv  = {fx_resp[2].rvalid, fx_resp[1].rvalid, fx_resp[0].rvalid};
    assign rr_gnt = {rr_resp[2].gnt, rr_resp[1].gnt, rr_resp[0].gnt};
    assign rr_rv  = {rr_resp[2].rvalid, rr_resp[1].rvalid, rr_resp[0].rvalid};

    int total = 0;
    int bad   = 0;

    obi_xbar_n_to_one_rr #(.NMASTER(3), .MAX_OUTSTANDING(4), .ARB_MODE(0)) u_fix (
        .clk_i         (clk),
        .rst_i         (rst),
        .master_req_i  (fx_req),
        .master_resp_o (fx_resp),
        .slave_req_o   (fx_sreq),
        .slave_resp_i  (fx_sresp),
        .busy_o        (fx_busy)
`ifdef OBI_XBAR_PERF_CNT_EN
        ,
        .gnt_cnt_o     (fx_cnt)
`endif
    );

    obi_xbar_n_to_one_rr #(.NMASTER(3), .MAX_OUTSTANDING(4), .ARB_MODE(1)) u_rr (
        .clk_i         (clk),
        .rst_i         (rst),
        .master_req_i  (rr_req),
        .master_resp_o (rr_resp),
        .slave_req_o   (rr_sreq),
        .slave_resp_i  (rr_sresp),
        .busy_o        (rr_busy)
`ifdef OBI_XBAR_PERF_CNT_EN
        ,
        .gnt_cnt_o     (rr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fx_drv(input int i, input logic req, input logic [31:0] addr);
        fx_req[i] = '{req: req, we: 1'b1, be: 4'hF, addr: addr, wdata: ~addr};
    endtask

    task automatic rr_drv(input int i, input logic req, input logic [31:0] addr);
        rr_req[i] = '{req: req, we: 1'b0, be: 4'hF, addr: addr, wdata: ~addr};
    endtask

    task automatic fx_slv(input logic gnt, input logic rvalid, input logic [31:0] rdata);
        fx_sresp = '{gnt: gnt, rvalid: rvalid, rdata: rdata};
    endtask

    task automatic rr_slv(input logic gnt, input logic rvalid, input logic [31:0] rdata);
        rr_sresp = '{gnt: gnt, rvalid: rvalid, rdata: rdata};
    endtask

    task automatic fx_idle();
        for (int i = 0; i < 3; i++) fx_drv(i, 1'b0, 32'h0);
        fx_slv(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        fx_idle();
        for (int i = 0; i < 3; i++) rr_drv(i, 1'b0, 32'h0);
        rr_slv(1'b0, 1'b0, 32'h0);

        // Reset: outputs forced low even with a requesting master and slave gnt/rvalid.
        @(negedge clk);
        fx_drv(0, 1'b1, 32'h100);
        fx_slv(1'b1, 1'b1, 32'h1);
        #1;
        chk("rst_req", 32'(fx_sreq.req), 32'h0);
        chk("rst_gnt", 32'(fx_gnt), 32'h0);
        chk("rst_rvalid", 32'(fx_rv), 32'h0);
        chk("rst_busy", 32'(fx_busy), 32'h0);
        @(negedge clk);
        fx_idle();
        rst = 1'b0;
        #1;
        chk("idle_addr_zero", fx_sreq.addr, 32'h0);
        chk("idle_req", 32'(fx_sreq.req), 32'h0);

        // Fixed priority: m0 and m2 together, m0 first.
        @(negedge clk);
        fx_drv(0, 1'b1, 32'h100);
        fx_drv(2, 1'b1, 32'h300);
        fx_slv(1'b1, 1'b0, 32'h0);
        #1;
        chk("fx_req_a", 32'(fx_sreq.req), 32'h1);
        chk("fx_addr_a", fx_sreq.addr, 32'h100);
        chk("fx_wdata_a", fx_sreq.wdata, 32'hFFFF_FEFF);
        chk("fx_gnt_a", 32'(fx_gnt), 32'h1);
        @(negedge clk);
        fx_drv(0, 1'b0, 32'h0);
        #1;
        chk("fx_addr_b", fx_sreq.addr, 32'h300);
        chk("fx_gnt_b", 32'(fx_gnt), 32'h4);
        chk("fx_busy_b", 32'(fx_busy), 32'h1);
        @(negedge clk);
        fx_idle();
        fx_slv(1'b0, 1'b1, 32'hAAAA);
        #1;
        chk("fx_rv_c", 32'(fx_rv), 32'h1);
        chk("fx_rdata_c", fx_resp[0].rdata, 32'hAAAA);
        @(negedge clk);
        fx_slv(1'b0, 1'b1, 32'hBBBB);
        #1;
        chk("fx_rv_d", 32'(fx_rv), 32'h4);
        chk("fx_rdata_d", fx_resp[2].rdata, 32'hBBBB);
        @(negedge clk);
        fx_idle();
        #1;
        chk("fx_busy_e", 32'(fx_busy), 32'h0);

        // Round-robin: three masters always requesting, one response per cycle after the first.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) rr_drv(i, 1'b1, 32'h1000 + 32'(i));
            rr_slv(1'b1, (k != 0), 32'(k));
            #1;
            chk($sformatf("rr_gnt_%0d", k), 32'(rr_gnt), 32'(1 << (k % 3)));
            chk($sformatf("rr_addr_%0d", k), rr_sreq.addr, 32'h1000 + 32'(k % 3));
            chk($sformatf("rr_rv_%0d", k), 32'(rr_rv), (k == 0) ? 32'h0 : 32'(1 << ((k - 1) % 3)));
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) rr_drv(i, 1'b0, 32'h0);
        rr_slv(1'b0, 1'b1, 32'h77);
        #1;
        chk("rr_drain_rv", 32'(rr_rv), 32'h4);
        @(negedge clk);
        rr_slv(1'b0, 1'b0, 32'h0);
        #1;
        chk("rr_busy_end", 32'(rr_busy), 32'h0);

        // Lock: m1 ungranted for three cycles, m0 joins but must wait.
        @(negedge clk);
        fx_drv(1, 1'b1, 32'h111);
        fx_slv(1'b0, 1'b0, 32'h0);
        #1;
        chk("lk1_req", 32'(fx_sreq.req), 32'h1);
        chk("lk1_addr", fx_sreq.addr, 32'h111);
        chk("lk1_gnt", 32'(fx_gnt), 32'h0);
        @(negedge clk);
        fx_drv(0, 1'b1, 32'h000);
        #1;
        chk("lk2_addr", fx_sreq.addr, 32'h111);
        chk("lk2_gnt", 32'(fx_gnt), 32'h0);
        @(negedge clk);
        #1;
        chk("lk3_addr", fx_sreq.addr, 32'h111);
        @(negedge clk);
        fx_slv(1'b1, 1'b0, 32'h0);
        #1;
        chk("lk4_addr", fx_sreq.addr, 32'h111);
        chk("lk4_gnt", 32'(fx_gnt), 32'h2);
        @(negedge clk);
        fx_drv(1, 1'b0, 32'h0);
        #1;
        chk("lk5_addr", fx_sreq.addr, 32'h000);
        chk("lk5_gnt", 32'(fx_gnt), 32'h1);

        // Push and pop together at count=2: response to oldest issuer (m1).
        @(negedge clk);
        fx_drv(0, 1'b0, 32'h0);
        fx_drv(2, 1'b1, 32'h222);
        fx_slv(1'b1, 1'b1, 32'h5);
        #1;
        chk("pp_rv", 32'(fx_rv), 32'h2);
        chk("pp_rdata", fx_resp[1].rdata, 32'h5);
        chk("pp_gnt", 32'(fx_gnt), 32'h4);

        // Fill to four outstanding (FIFO holds 0,2 then 2,2).
        @(negedge clk);
        fx_slv(1'b1, 1'b0, 32'h0);
        #1;
        chk("fill3_gnt", 32'(fx_gnt), 32'h4);
        @(negedge clk);
        #1;
        chk("fill4_gnt", 32'(fx_gnt), 32'h4);
        @(negedge clk);
        #1;
        chk("full_req", 32'(fx_sreq.req), 32'h0);
        chk("full_gnt", 32'(fx_gnt), 32'h0);
        chk("full_busy", 32'(fx_busy), 32'h1);
        @(negedge clk);
        fx_slv(1'b1, 1'b1, 32'h9);
        #1;
        chk("full_pop_req", 32'(fx_sreq.req), 32'h0);
        chk("full_pop_rv", 32'(fx_rv), 32'h1);
        @(negedge clk);
        fx_slv(1'b1, 1'b0, 32'h0);
        #1;
        chk("reassert_req", 32'(fx_sreq.req), 32'h1);
        chk("reassert_gnt", 32'(fx_gnt), 32'h4);

        // Reset with transactions outstanding, then a stale response.
        @(negedge clk);
        rst = 1'b1;
        fx_slv(1'b1, 1'b1, 32'hDEAD);
        #1;
        chk("mrst_req", 32'(fx_sreq.req), 32'h0);
        chk("mrst_busy", 32'(fx_busy), 32'h0);
        chk("mrst_rv", 32'(fx_rv), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        fx_idle();
        fx_slv(1'b0, 1'b1, 32'hBEEF);
        #1;
        chk("stale_rv", 32'(fx_rv), 32'h0);
        chk("stale_busy", 32'(fx_busy), 32'h0);
`ifdef OBI_XBAR_PERF_CNT_EN
        chk("cnt0_after_rst", fx_cnt[0], 32'h0);
        chk("cnt2_after_rst", fx_cnt[2], 32'h0);
`endif

        // Five back-to-back grants to m0 with pipelined responses.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            fx_drv(0, 1'b1, 32'h500 + 32'(k));
            fx_slv(1'b1, (k != 0), 32'(k));
            #1;
            chk($sformatf("m0_gnt_%0d", k), 32'(fx_gnt), 32'h1);
            chk($sformatf("m0_rv_%0d", k), 32'(fx_rv), (k == 0) ? 32'h0 : 32'h1);
        end
        @(negedge clk);
        fx_idle();
        fx_slv(1'b0, 1'b1, 32'h0);
        #1;
        chk("m0_drain_rv", 32'(fx_rv), 32'h1);
        @(negedge clk);
        fx_idle();
        #1;
        chk("m0_busy_end", 32'(fx_busy), 32'h0);
`ifdef OBI_XBAR_PERF_CNT_EN
        chk("cnt0_five", fx_cnt[0], 32'd5);
        chk("cnt1_zero", fx_cnt[1], 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
